// File: rtl/mul_pkg.sv
// Op encoding shared by the pipelined multiplier and its users.
// The op is three flag bits: signed operands, accumulate, subtract.
package mul_pkg;

  localparam int MUL_OP_W = 3;

  localparam int MUL_SGN = 0;
  localparam int MUL_ACC = 1;
  localparam int MUL_SUB = 2;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL_MULTU = 3'b000,
    MUL_MULT  = 3'b001,
    MUL_MADDU = 3'b010,
    MUL_MADD  = 3'b011,
    MUL_MSUBU = 3'b110,
    MUL_MSUB  = 3'b111
  } mul_op_e;

  function automatic logic op_signed(input logic [MUL_OP_W-1:0] op);
    return op[MUL_SGN];
  endfunction

  function automatic logic op_acc(input logic [MUL_OP_W-1:0] op);
    return op[MUL_ACC];
  endfunction

  // A set sub bit without acc is an unused code and falls back to a plain multiply.
  function automatic logic op_sub(input logic [MUL_OP_W-1:0] op);
    return op[MUL_SUB];
  endfunction

endpackage

// File: rtl/mul_pipe_slice.sv
// One pipeline slice: a valid bit plus payload register.
// The slice loads whenever its advance input is high and the pipe is not stalled.
module mul_pipe_slice
  import mul_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          stall,
  input  logic          advance,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!stall && advance) begin
      valid <= up_valid;
    end
  end

  // Payload needs no reset; it is only observed when the valid bit is set.
  always_ff @(posedge clk) begin
    if (!stall && advance) begin
      data <= up_data;
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined multiply / multiply-accumulate unit with valid/ready flow control.
// S1 holds extended operands, the product is registered into S2, the accumulate lands in S_LAT.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int W     = 32,
  parameter int LAT   = 4,
  parameter int TAG_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [W-1:0]        in_a,
  input  logic [W-1:0]        in_b,
  input  logic [2*W-1:0]      in_acc,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_hi,
  output logic [W-1:0]        out_lo,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);

  typedef struct packed {
    logic [MUL_OP_W-1:0] op;
    logic [TAG_W-1:0]    tag;
    logic [W:0]          a;
    logic [W:0]          b;
    logic [2*W-1:0]      acc;
    logic [2*W-1:0]      prod;
  } payload_t;

  localparam int PW = $bits(payload_t);

  logic [LAT:1] slot_valid;
  logic [LAT:1] slot_adv;
  payload_t     slot_data [1:LAT];
  payload_t     head;

  // Operands are W+1 bits; extending them further to 2W bits gives the product modulo 2^(2W).
  function automatic logic [2*W-1:0] mul_ext(input logic [W:0] a, input logic [W:0] b);
    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;
    ax = {{(W-1){a[W]}}, a};
    bx = {{(W-1){b[W]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [2*W-1:0] finish_result(input logic [MUL_OP_W-1:0] op,
                                                   input logic [2*W-1:0] acc,
                                                   input logic [2*W-1:0] prod);
    logic [2*W-1:0] r;
    r = prod;
    if (op_acc(op)) begin
      r = op_sub(op) ? (acc - prod) : (acc + prod);
    end
    return r;
  endfunction

  // Work done on the way into slice k; with LAT=2 both steps happen into S2.
  function automatic payload_t stage_next(input int k, input payload_t p);
    payload_t n;
    n = p;
    if (k == 2) begin
      n.prod = mul_ext(p.a, p.b);
    end
    if (k == LAT) begin
      n.prod = finish_result(n.op, n.acc, n.prod);
    end
    return n;
  endfunction

  always_comb begin
    head      = '0;
    head.op   = in_op;
    head.tag  = in_tag;
    head.a    = op_signed(in_op) ? {in_a[W-1], in_a} : {1'b0, in_a};
    head.b    = op_signed(in_op) ? {in_b[W-1], in_b} : {1'b0, in_b};
    head.acc  = in_acc;
    head.prod = '0;
  end

  // Advance ripples from the output back toward S1 so bubbles collapse in one cycle.
  always_comb begin
    slot_adv      = '0;
    slot_adv[LAT] = ~slot_valid[LAT] | out_ready;
    for (int k = LAT - 1; k >= 1; k--) begin
      slot_adv[k] = ~slot_valid[k] | slot_adv[k+1];
    end
  end

  assign in_ready = ~stall & ~flush & slot_adv[1];

  for (genvar k = 1; k <= LAT; k++) begin : g_stage
    logic          up_valid;
    payload_t      up_data;
    logic [PW-1:0] q;

    if (k == 1) begin : g_head
      assign up_valid = in_valid & in_ready;
      assign up_data  = head;
    end else begin : g_body
      assign up_valid = slot_valid[k-1];
      assign up_data  = stage_next(k, slot_data[k-1]);
    end

    mul_pipe_slice #(
      .DW(PW)
    ) u_slice (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .stall   (stall),
      .advance (slot_adv[k]),
      .up_valid(up_valid),
      .up_data (up_data),
      .valid   (slot_valid[k]),
      .data    (q)
    );

    assign slot_data[k] = q;
  end

  assign out_valid        = slot_valid[LAT] & ~stall;
  assign {out_hi, out_lo} = slot_data[LAT].prod;
  assign out_tag          = slot_data[LAT].tag;
  assign busy             = |slot_valid;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: arithmetic modes, latency, backpressure, flush, stall, reset.
module tb_mul_pipe;
  import mul_pkg::*;

  localparam int W     = 32;
  localparam int LAT   = 4;
  localparam int TAG_W = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [W-1:0]       in_a;
  logic [W-1:0]       in_b;
  logic [2*W-1:0]     in_acc;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_hi;
  logic [W-1:0]       out_lo;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_pipe #(
    .W(W),
    .LAT(LAT),
    .TAG_W(TAG_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_acc   (in_acc),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hi   (out_hi),
    .out_lo   (out_lo),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Presents one op for a single cycle; called just after a falling edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] acc, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_acc   = acc;
    in_tag   = tag;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles from the issue cycle until out_valid, then checks latency, tag and value.
  task automatic waitResult(input string name, input logic [TAG_W-1:0] tag, input logic [63:0] exp);
    int cnt = 1;
    #1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    checkOutput({name, "_lat"}, 64'(cnt), 64'(LAT));
    checkOutput({name, "_tag"}, 64'(out_tag), 64'(tag));
    checkOutput({name, "_res"}, {out_hi, out_lo}, exp);
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    int cnt;

    reset     = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_acc    = '0;
    in_tag    = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(MUL_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0, 6'h15);
    waitResult("mult", 6'h15, 64'hFFFF_FFFF_FFFF_FFFE);
    applyStimulus(MUL_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0, 6'h16);
    waitResult("multu", 6'h16, 64'h0000_0001_FFFF_FFFE);
    applyStimulus(MUL_MADD, 32'h1, 32'h1, 64'h0000_0000_FFFF_FFFF, 6'h17);
    waitResult("madd", 6'h17, 64'h0000_0001_0000_0000);
    applyStimulus(MUL_MSUBU, 32'h1, 32'h1, 64'h0, 6'h18);
    waitResult("msubu", 6'h18, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(MUL_MSUB, 32'hFFFF_FFFD, 32'h4, 64'd10, 6'h19);
    waitResult("msub", 6'h19, 64'h0000_0000_0000_0016);
    applyStimulus(MUL_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h1A);
    waitResult("maddu", 6'h1A, 64'hFFFF_FFFE_0000_0000);
    applyStimulus(3'b100, 32'h3, 32'h5, 64'd100, 6'h1B);
    waitResult("unused_code", 6'h1B, 64'h0000_0000_0000_000F);

    // Backpressure: hold the output for six cycles while offering eight ops.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while ((sent < 8 || recv < 8) && cyc < 60) begin
      out_ready = (cyc >= 6);
      in_valid  = (sent < 8);
      in_op     = MUL_MULTU;
      in_tag    = TAG_W'(sent);
      in_a      = W'(sent + 1);
      in_b      = 32'h10;
      in_acc    = '0;
      #1;
      if (cyc == 5) begin
        checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
        checkOutput("bp_accepted", 64'(sent), 64'd4);
        checkOutput("bp_head_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_head_tag", 64'(out_tag), 64'd0);
      end
      if (out_valid && out_ready) begin
        checkOutput("bp_tag", 64'(out_tag), 64'(recv));
        checkOutput("bp_prod", {out_hi, out_lo}, 64'((recv + 1) * 16));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_sent", 64'(sent), 64'd8);
    checkOutput("bp_recv", 64'(recv), 64'd8);
    #1;
    checkOutput("bp_drained_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_drained_busy", 64'(busy), 64'd0);
    @(negedge clk);

    // Flush with three ops in flight; the op offered during flush is dropped.
    applyStimulus(MUL_MULTU, 32'h1, 32'h1, 64'h0, 6'h20);
    applyStimulus(MUL_MULTU, 32'h2, 32'h1, 64'h0, 6'h21);
    applyStimulus(MUL_MULTU, 32'h3, 32'h1, 64'h0, 6'h22);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = MUL_MULTU;
    in_a     = 32'h9;
    in_b     = 32'h9;
    in_tag   = 6'h2F;
    #1;
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    applyStimulus(MUL_MULT, 32'h7, 32'hFFFF_FFFE, 64'h0, 6'h23);
    waitResult("post_flush", 6'h23, 64'hFFFF_FFFF_FFFF_FFF2);
    #1;
    checkOutput("post_flush_idle", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Stall five cycles mid-stream; an op offered during the stall must not enter.
    applyStimulus(MUL_MULT, 32'hFFFF_FFFB, 32'h7, 64'h0, 6'h30);
    applyStimulus(MUL_MADD, 32'h6, 32'h7, 64'd100, 6'h31);
    @(negedge clk);
    stall    = 1'b1;
    in_valid = 1'b1;
    in_op    = MUL_MULTU;
    in_a     = 32'h5;
    in_b     = 32'h5;
    in_acc   = '0;
    in_tag   = 6'h3F;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("stall_out_valid", 64'(out_valid), 64'd0);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    cnt      = 0;
    #1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    checkOutput("stall_resume_lat", 64'(cnt), 64'd1);
    checkOutput("stall_first_tag", 64'(out_tag), 64'h30);
    checkOutput("stall_first_res", {out_hi, out_lo}, 64'hFFFF_FFFF_FFFF_FFDD);
    @(negedge clk);
    #1;
    checkOutput("stall_second_valid", 64'(out_valid), 64'd1);
    checkOutput("stall_second_tag", 64'(out_tag), 64'h31);
    checkOutput("stall_second_res", {out_hi, out_lo}, 64'd142);
    @(negedge clk);
    #1;
    checkOutput("stall_no_extra", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Reset with two ops in flight, then one clean op.
    applyStimulus(MUL_MULTU, 32'h3, 32'h3, 64'h0, 6'h38);
    applyStimulus(MUL_MULTU, 32'h4, 32'h4, 64'h0, 6'h39);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    applyStimulus(MUL_MULTU, 32'h1234_5678, 32'h10, 64'h0, 6'h3A);
    waitResult("post_reset", 6'h3A, 64'h0000_0001_2345_6780);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
Parametrised, fully pipelined integer multiply/multiply-accumulate unit for the EX stage.
- Accepts one op per cycle over a valid/ready handshake and carries a ROB tag alongside.
- Returns a 2*W-bit HI/LO result after a configurable latency.
- Supports signed/unsigned multiply, multiply-add and multiply-subtract, with per-stage backpressure, global stall and flush.
- Sits between issue/operand-read and the writeback arbiter.

Parameters:
W, 32, operand width in bits; result is 2*W.
LAT, 4, pipeline depth in cycles from input fire to out_valid (LAT >= 2).
TAG_W, 6, width of the opaque tag (ROB index + age bit) carried with each op.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  global freeze; no state changes while high
flush  in  1  kill all in-flight ops
in_valid  in  1  op presented
in_ready  out  1  unit can accept this cycle
in_op  in  3  mode {sub, acc, sgn} (see package)
in_a  in  W  multiplicand
in_b  in  W  multiplier
in_acc  in  2*W  accumulator {HI,LO}; used only when acc=1
in_tag  in  TAG_W  op tag
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_hi  out  W  upper half of result
out_lo  out  W  lower half of result
out_tag  out  TAG_W  tag of result
busy  out  1  any stage holds a valid op (HI/LO hazard indication)

Behaviour:
- Reset (reset=1 at posedge clk): all stage valid bits cleared.
  - out_valid=0 and busy=0 from the next cycle.
  - Data/tag registers need no reset; out_hi/out_lo/out_tag are don't-care while out_valid=0.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Stage model: LAT slices S1..S_LAT, each holding {valid, op, tag, data}. S_LAT drives the outputs.
- Slice advance: slice k advances when it is empty, or when slice k+1 advances. S_LAT advances on out_fire or when empty. Bubbles collapse: an empty slice always accepts.
- in_ready = ~stall & ~flush & (S1 empty | S1 advances). It is combinational from out_ready through the advance chain.
- out_valid = S_LAT.valid & ~stall.
- Latency: exactly LAT cycles from in_fire to out_valid when there is no backpressure. Throughput is 1 op/cycle. Ops emerge in issue order.
- Arithmetic:
  - S1 registers the operands, sign-extended to W+1 bits when sgn=1, otherwise zero-extended.
  - The full 2*W product is formed across S1..S_LAT-1. Retiming is free provided latency is exact.
  - S_LAT computes P when acc=0, in_acc+P when acc=1,sub=0, and in_acc-P when acc=1,sub=1.
  - All results are modulo 2^(2W); no overflow flag. in_acc travels with the op.
  - Unused op codes (acc=0, sub=1) behave as plain multiply.
- Stall (synchronous): all registers hold, in_ready=0, out_valid=0, and no transfer occurs.
- Flush: every valid bit clears at this edge. An input offered in the flush cycle is dropped (in_ready=0). The op accepted on the cycle after flush is processed normally.
- Precedence: reset > flush > stall > normal advance.
- A full pipeline with out_ready=0 holds exactly LAT ops; in_ready=0 until out_fire.
- busy = OR of all slice valid bits (unaffected by stall).

Decomposition:
- Package mul_pkg:
  - MUL_OP_W=3.
  - Bit indices MUL_SGN=0, MUL_ACC=1, MUL_SUB=2.
  - Named codes MUL_MULT=3'b001, MUL_MULTU=3'b000, MUL_MADD=3'b011, MUL_MADDU=3'b010, MUL_MSUB=3'b111, MUL_MSUBU=3'b110.
- One sub-module, mul_pipe_slice (parameter DW): a valid/data register with advance/accept logic, instantiated per stage by a generate loop.

Test Plan:
1. MULT, a=0xFFFFFFFF, b=0x00000002, tag=0x15, W=32, LAT=4 -> exactly 4 cycles later out_valid=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE, tag=0x15.
2. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
3. Accumulate modes:
   - MADD, acc=0x00000000_FFFFFFFF, a=1, b=1 -> hi=0x00000001, lo=0x00000000.
   - MSUBU, acc=0, a=1, b=1 -> hi=lo=0xFFFFFFFF.
4. Backpressure: 8 back-to-back ops with tags 0..7, out_ready=0 -> in_ready falls after 4 accepted. Raising out_ready -> tags 0..7 emerge in order with correct products and no loss or duplication.
5. Flush and stall:
   - 3 ops in flight, pulse flush -> no out_valid for those tags. A new op issued the next cycle appears 4 cycles later.
   - stall held 5 cycles mid-stream -> outputs frozen, results unchanged after release.
6. Reset asserted with 2 ops in flight -> next cycle busy=0 and out_valid=0. The first post-reset op completes with correct value and latency.
